controlador_contagem_bcd: RTL and testbench
===========================================

Name: controlador_contagem_bcd

Overview:
- Controller that sequences the counting datapath: run, pause and clear commands; up/down direction; programmable wrap limit.
- Consumes the slow tick from the frequency divider and owns the count register.
- Drives a serial shift-add-3 (double-dabble) binary-to-BCD conversion and presents tens/units digits to the display registers with a validity flag.
- Sits between the frequency divider and the two-digit display in the top-level.

Parameters:
- LARGURA, 4, count width in bits; legal range 4..6, so the tens digit is at most 6 and fits in 4 bits.

Ports:
- clock  in  1  main clock; all state changes on its rising edge
- resetN  in  1  synchronous reset, active-low
- tick  in  1  one-cycle enable pulse from the frequency divider
- iniciar  in  1  start/resume command (level sampled each cycle)
- pausar  in  1  pause command
- zerar  in  1  clear command
- sentido  in  1  1 = count up, 0 = count down
- limite  in  LARGURA  wrap value (count range 0..limite)
- valorAtual  out  LARGURA  current count
- dezena  out  4  BCD tens digit of last converted value
- unidade  out  4  BCD units digit of last converted value
- bcdValido  out  1  1 when dezena/unidade represent valorAtual
- estado  out  2  00 PARADO, 01 CONTANDO, 10 PAUSADO
- fimContagem  out  1  one-cycle pulse on wrap

Behaviour:
- Single clock. Reset is synchronous, active-low.
- Reset (resetN=0 at a clock edge):
  - valorAtual=0, dezena=0, unidade=0, bcdValido=1, estado=PARADO, fimContagem=0.
  - Any conversion in progress is aborted.
  - Reset applies mid-count or mid-conversion with no residue.
- Command priority, evaluated each cycle: zerar > pausar > iniciar.
  - zerar: valorAtual<=0, estado<=PARADO. Legal in any state.
  - pausar in CONTANDO: estado<=PAUSADO. Ignored in other states.
  - iniciar in PARADO or PAUSADO: estado<=CONTANDO. Ignored in CONTANDO.
  - estado 11 is unreachable; if entered, it returns to PARADO next cycle.
- Counting happens only when estado==CONTANDO at the edge, tick=1, and no zerar or pausar in the same cycle.
  - A tick in the same cycle as iniciar is not counted; the state change takes effect first.
  - Ticks in PARADO or PAUSADO are ignored. PAUSADO preserves valorAtual.
- Up (sentido=1):
  - If valorAtual >= limite: valorAtual<=0 and fimContagem=1 for one cycle.
  - Else: valorAtual+1.
  - This covers limite lowered below the current value.
- Down (sentido=0):
  - If valorAtual==0 or valorAtual > limite: valorAtual<=limite and fimContagem=1.
  - Else: valorAtual-1.
- limite=0: the count stays at 0 and fimContagem pulses on every counted tick.
- sentido may change at any time and takes effect on the next counted tick.
- Conversion sub-FSM (LIVRE, CONVERTENDO):
  - Starts the cycle after any change of valorAtual, including zerar when the value was nonzero.
  - Takes exactly LARGURA shift cycles, with the add-3 correction applied before each shift.
  - Result lands in dezena/unidade on the edge ending the last shift.
  - Update-to-digits latency is LARGURA+1 cycles (5 for the default).
- bcdValido:
  - Drops to 0 on the edge where valorAtual changes.
  - Returns to 1 on the edge the digits latch.
  - dezena/unidade hold their old values during conversion; they are never partially updated.
- valorAtual changes during a conversion:
  - A pending flag is set and the current conversion runs to completion.
  - The digits latch, but bcdValido stays 0.
  - A new conversion of the latest value starts the next cycle.
  - Only the most recent value is converted; intermediate values are dropped.
- Digit range: dezena ≤ 6 for LARGURA=6, 0 for any value < 10; unidade ≤ 9 always.

Test Plan:
- Reset, then iniciar, sentido=1, limite=15, 20 ticks spaced 8 cycles apart → valorAtual 1..15, 0..4. fimContagem pulses once, on 15→0. Once bcdValido=1: dezena/unidade=1/2 at value 12 and 0/0 after the wrap.
- Count to 9, then one tick → bcdValido low for exactly 5 cycles, then dezena=1, unidade=0. Digits show 0/9 throughout the conversion window.
- Running at 7: pausar with a tick in the same cycle → estado=PAUSADO, value stays 7 across 3 ticks. iniciar with a simultaneous tick → still 7; the next tick gives 8.
- sentido=0, limite=10, value 0, tick → value 10 with fimContagem pulse. Next tick → 9.
- Value 14, limite changed to 5, sentido=1, tick → value 0 with fimContagem. zerar+pausar+iniciar in the same cycle → PARADO, value 0.
- Ticks on consecutive cycles during a conversion → bcdValido goes high only after the final value converts; digits match that final value. resetN=0 mid-conversion → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/controlador_contagem_bcd.sv
// Counting controller: run/pause/clear sequencing, up/down count with a programmable wrap,
// and a serial double-dabble converter that feeds the two-digit display.
module controlador_contagem_bcd #(
  parameter int LARGURA = 4
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               tick,
  input  logic               iniciar,
  input  logic               pausar,
  input  logic               zerar,
  input  logic               sentido,
  input  logic [LARGURA-1:0] limite,
  output logic [LARGURA-1:0] valorAtual,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade,
  output logic               bcdValido,
  output logic [1:0]         estado,
  output logic               fimContagem
);

  typedef enum logic [1:0] {
    PARADO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10
  } estado_t;

  typedef enum logic {
    LIVRE,
    CONVERTENDO
  } conv_t;

  localparam int CW = $clog2(LARGURA);

  estado_t            estado_q;
  conv_t              conv_q;
  logic               pendente_q;
  logic [CW-1:0]      passo_q;
  logic [7:0]         bcd_q;
  logic [LARGURA-1:0] bin_q;

  logic [LARGURA-1:0] valor_prox;
  logic               fim_prox;
  logic               conta;
  logic               mudou;
  logic [7:0]         bcd_aj;
  logic [7:0]         bcd_sh;
  logic [LARGURA-1:0] bin_sh;
  logic               ultimo;

  assign estado = estado_q;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    valor_prox = valorAtual;
    fim_prox   = 1'b0;
    conta      = (estado_q == CONTANDO) && tick && !zerar && !pausar;
    if (zerar) begin
      valor_prox = '0;
    end else if (conta) begin
      if (sentido) begin
        if (valorAtual >= limite) begin
          valor_prox = '0;
          fim_prox   = 1'b1;
        end else begin
          valor_prox = valorAtual + LARGURA'(1);
        end
      end else begin
        if (valorAtual == '0 || valorAtual > limite) begin
          valor_prox = limite;
          fim_prox   = 1'b1;
        end else begin
          valor_prox = valorAtual - LARGURA'(1);
        end
      end
    end
  end

  assign mudou = (valor_prox != valorAtual);

  // Add-3 correction on each nibble, then one left shift of the {bcd, binary} pair.
  always_comb begin
    bcd_aj = bcd_q;
    if (bcd_aj[3:0] >= 4'd5) bcd_aj[3:0] = bcd_aj[3:0] + 4'd3;
    if (bcd_aj[7:4] >= 4'd5) bcd_aj[7:4] = bcd_aj[7:4] + 4'd3;
    bcd_sh = {bcd_aj[6:0], bin_q[LARGURA-1]};
    bin_sh = bin_q << 1;
  end

  assign ultimo = (passo_q == CW'(LARGURA - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      valorAtual  <= '0;
      fimContagem <= 1'b0;
      estado_q    <= PARADO;
      conv_q      <= LIVRE;
      pendente_q  <= 1'b0;
      passo_q     <= '0;
      bcd_q       <= '0;
      bin_q       <= '0;
      dezena      <= '0;
      unidade     <= '0;
      bcdValido   <= 1'b1;
    end else begin
      valorAtual  <= valor_prox;
      fimContagem <= fim_prox;

      if (zerar) begin
        estado_q <= PARADO;
      end else begin
        case (estado_q)
          PARADO:   if (!pausar && iniciar) estado_q <= CONTANDO;
          CONTANDO: if (pausar) estado_q <= PAUSADO;
          PAUSADO:  if (!pausar && iniciar) estado_q <= CONTANDO;
          default:  estado_q <= PARADO;
        endcase
      end

      if (mudou) bcdValido <= 1'b0;

      // A change seen while busy is remembered; only the newest value is converted afterwards.
      case (conv_q)
        LIVRE: begin
          pendente_q <= mudou;
          if (pendente_q) begin
            bcd_q   <= '0;
            bin_q   <= valorAtual;
            passo_q <= '0;
            conv_q  <= CONVERTENDO;
          end
        end
        CONVERTENDO: begin
          pendente_q <= pendente_q | mudou;
          bcd_q      <= bcd_sh;
          bin_q      <= bin_sh;
          passo_q    <= passo_q + CW'(1);
          if (ultimo) begin
            dezena  <= bcd_sh[7:4];
            unidade <= bcd_sh[3:0];
            conv_q  <= LIVRE;
            if (!pendente_q && !mudou) bcdValido <= 1'b1;
          end
        end
        default: conv_q <= LIVRE;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_contagem_bcd.sv
// Self-checking bench: table vectors, directed corner sequences and random stimulus
// compared each cycle against an arithmetic reference model of the count and display.
module tb_controlador_contagem_bcd;

  localparam int L = 4;

  logic         clock = 1'b0;
  logic         resetN, tick, iniciar, pausar, zerar, sentido;
  logic [L-1:0] limite;
  logic [L-1:0] valorAtual;
  logic [3:0]   dezena, unidade;
  logic         bcdValido;
  logic [1:0]   estado;
  logic         fimContagem;

  int checks   = 0;
  int failures = 0;

  // Reference model: count value, state (0 stopped, 1 running, 2 paused), wrap pulse,
  // and cycles since the value last changed.
  int m_val, m_est, m_fim, quieto;

  controlador_contagem_bcd #(.LARGURA(L)) dut (
    .clock(clock), .resetN(resetN), .tick(tick), .iniciar(iniciar), .pausar(pausar),
    .zerar(zerar), .sentido(sentido), .limite(limite), .valorAtual(valorAtual),
    .dezena(dezena), .unidade(unidade), .bcdValido(bcdValido), .estado(estado),
    .fimContagem(fimContagem)
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input int atual, input int esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic modelo_borda();
    int anterior = m_val;
    int lim = int'(limite);
    if (!resetN) begin
      m_val = 0; m_est = 0; m_fim = 0; quieto = 100;
    end else begin
      m_fim = 0;
      if (zerar) begin
        m_val = 0; m_est = 0;
      end else begin
        if (m_est == 1 && tick && !pausar) begin
          if (sentido) begin
            if (m_val >= lim) begin m_val = 0; m_fim = 1; end
            else m_val = m_val + 1;
          end else begin
            if (m_val == 0 || m_val > lim) begin m_val = lim; m_fim = 1; end
            else m_val = m_val - 1;
          end
        end
        if (pausar) begin
          if (m_est == 1) m_est = 2;
        end else if (iniciar && m_est != 1) begin
          m_est = 1;
        end
      end
      if (m_val != anterior) quieto = 0;
      else if (quieto < 100) quieto++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    modelo_borda();
    #1;
    check("valor", int'(valorAtual), m_val);
    check("estado", int'(estado), m_est);
    check("fim", int'(fimContagem), m_fim);
    if (quieto == 0) check("valido_cai", int'(bcdValido), 0);
    if (quieto > 2 * L + 1) check("valido_volta", int'(bcdValido), 1);
    if (bcdValido === 1'b1) begin
      check("dezena", int'(dezena), m_val / 10);
      check("unidade", int'(unidade), m_val % 10);
    end
  endtask

  task automatic ciclo(input bit t, input bit ini, input bit pau, input bit zer);
    tick = t; iniciar = ini; pausar = pau; zerar = zer;
    step();
    tick = 0; iniciar = 0; pausar = 0; zerar = 0;
  endtask

  typedef struct {
    bit tk, ini, pau, zer, sen;
    int lim;
    int val, est, fim;
  } vetor_t;

  vetor_t tabela[20];

  initial begin
    int fims;
    int n;

    resetN = 0; tick = 0; iniciar = 0; pausar = 0; zerar = 0; sentido = 1; limite = 4'd15;
    m_val = 0; m_est = 0; m_fim = 0; quieto = 100;
    step();
    step();
    check("reset_valido", int'(bcdValido), 1);
    check("reset_dezena", int'(dezena), 0);
    resetN = 1;

    // A: count up to 15, wrap, continue to 4
    ciclo(0, 1, 0, 0);
    fims = 0;
    for (int i = 1; i <= 20; i++) begin
      ciclo(1, 0, 0, 0);
      check("A_valor", int'(valorAtual), i % 16);
      fims += int'(fimContagem);
      repeat (7) ciclo(0, 0, 0, 0);
      check("A_valido", int'(bcdValido), 1);
      check("A_dezena", int'(dezena), (i % 16) / 10);
      check("A_unidade", int'(unidade), (i % 16) % 10);
    end
    check("A_fims", fims, 1);

    // B: 9 -> 10, exact conversion window with old digits held
    for (int i = 0; i < 5; i++) begin
      ciclo(1, 0, 0, 0);
      repeat (7) ciclo(0, 0, 0, 0);
    end
    check("B_nove", int'(valorAtual), 9);
    ciclo(1, 0, 0, 0);
    check("B_valido_e0", int'(bcdValido), 0);
    check("B_dez_e0", int'(dezena), 0);
    check("B_uni_e0", int'(unidade), 9);
    for (int k = 1; k <= 4; k++) begin
      ciclo(0, 0, 0, 0);
      check("B_valido_janela", int'(bcdValido), 0);
      check("B_dez_janela", int'(dezena), 0);
      check("B_uni_janela", int'(unidade), 9);
    end
    ciclo(0, 0, 0, 0);
    check("B_valido_fim", int'(bcdValido), 1);
    check("B_dez_fim", int'(dezena), 1);
    check("B_uni_fim", int'(unidade), 0);

    // C: pause with tick, resume with tick
    ciclo(0, 0, 0, 1);
    ciclo(0, 1, 0, 0);
    repeat (7) ciclo(1, 0, 0, 0);
    check("C_sete", int'(valorAtual), 7);
    ciclo(1, 0, 1, 0);
    check("C_pausado", int'(estado), 2);
    check("C_pausa_valor", int'(valorAtual), 7);
    repeat (3) ciclo(1, 0, 0, 0);
    check("C_pausa_mantem", int'(valorAtual), 7);
    ciclo(1, 1, 0, 0);
    check("C_retoma_valor", int'(valorAtual), 7);
    check("C_retoma_estado", int'(estado), 1);
    ciclo(1, 0, 0, 0);
    check("C_oito", int'(valorAtual), 8);

    // D: count down from 0 wraps to limite
    ciclo(0, 0, 0, 1);
    sentido = 0; limite = 4'd10;
    ciclo(0, 1, 0, 0);
    ciclo(1, 0, 0, 0);
    check("D_dez", int'(valorAtual), 10);
    check("D_fim", int'(fimContagem), 1);
    ciclo(1, 0, 0, 0);
    check("D_nove", int'(valorAtual), 9);
    check("D_sem_fim", int'(fimContagem), 0);

    // E: limite lowered below the count, then all commands at once
    ciclo(0, 0, 0, 1);
    sentido = 1; limite = 4'd15;
    ciclo(0, 1, 0, 0);
    repeat (14) ciclo(1, 0, 0, 0);
    check("E_quatorze", int'(valorAtual), 14);
    limite = 4'd5;
    ciclo(1, 0, 0, 0);
    check("E_wrap", int'(valorAtual), 0);
    check("E_fim", int'(fimContagem), 1);
    ciclo(1, 0, 0, 0);
    ciclo(0, 1, 1, 1);
    check("E_todos_estado", int'(estado), 0);
    check("E_todos_valor", int'(valorAtual), 0);

    // F: back-to-back ticks, then reset in the middle of a conversion
    repeat (12) ciclo(0, 0, 0, 0);
    limite = 4'd15;
    ciclo(0, 1, 0, 0);
    repeat (6) ciclo(1, 0, 0, 0);
    n = 0;
    while (bcdValido !== 1'b1 && n < 20) begin
      ciclo(0, 0, 0, 0);
      n++;
    end
    check("F_convergiu", int'(bcdValido), 1);
    check("F_dezena", int'(dezena), 0);
    check("F_unidade", int'(unidade), 6);
    ciclo(1, 0, 0, 0);
    repeat (2) ciclo(0, 0, 0, 0);
    resetN = 0;
    ciclo(0, 0, 0, 0);
    check("F_rst_valor", int'(valorAtual), 0);
    check("F_rst_dezena", int'(dezena), 0);
    check("F_rst_unidade", int'(unidade), 0);
    check("F_rst_valido", int'(bcdValido), 1);
    check("F_rst_estado", int'(estado), 0);
    check("F_rst_fim", int'(fimContagem), 0);
    resetN = 1;
    repeat (8) ciclo(0, 0, 0, 0);
    check("F_sem_residuo_uni", int'(unidade), 0);
    check("F_sem_residuo_val", int'(bcdValido), 1);

    // Table vectors from a fresh reset
    tabela[0]  = '{1, 1, 0, 0, 1, 3, 0, 1, 0};
    tabela[1]  = '{1, 0, 0, 0, 1, 3, 1, 1, 0};
    tabela[2]  = '{1, 0, 0, 0, 1, 3, 2, 1, 0};
    tabela[3]  = '{1, 0, 0, 0, 1, 3, 3, 1, 0};
    tabela[4]  = '{1, 0, 0, 0, 1, 3, 0, 1, 1};
    tabela[5]  = '{0, 0, 0, 0, 1, 3, 0, 1, 0};
    tabela[6]  = '{1, 0, 1, 0, 1, 3, 0, 2, 0};
    tabela[7]  = '{1, 0, 0, 0, 1, 3, 0, 2, 0};
    tabela[8]  = '{0, 1, 0, 0, 1, 3, 0, 1, 0};
    tabela[9]  = '{1, 0, 0, 0, 0, 3, 3, 1, 1};
    tabela[10] = '{1, 0, 0, 0, 0, 3, 2, 1, 0};
    tabela[11] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    tabela[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tabela[13] = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tabela[14] = '{1, 0, 0, 0, 1, 0, 0, 1, 1};
    tabela[15] = '{1, 1, 0, 1, 1, 5, 0, 0, 0};
    tabela[16] = '{0, 1, 0, 0, 1, 5, 0, 1, 0};
    tabela[17] = '{1, 0, 0, 0, 1, 5, 1, 1, 0};
    tabela[18] = '{1, 1, 0, 0, 1, 5, 2, 1, 0};
    tabela[19] = '{0, 0, 0, 1, 1, 5, 0, 0, 0};
    resetN = 0;
    ciclo(0, 0, 0, 0);
    resetN = 1;
    for (int i = 0; i < 20; i++) begin
      sentido = tabela[i].sen;
      limite  = tabela[i].lim[L-1:0];
      ciclo(tabela[i].tk, tabela[i].ini, tabela[i].pau, tabela[i].zer);
      check("tab_valor", int'(valorAtual), tabela[i].val);
      check("tab_estado", int'(estado), tabela[i].est);
      check("tab_fim", int'(fimContagem), tabela[i].fim);
    end

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      resetN = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) sentido = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) limite = 4'($urandom_range(0, 15));
      ciclo($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
    end
    resetN = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
